// File: rtl/alu_reservation_station.sv
// -----------------------------------------------------------------------------
// alu_reservation_station
//
// Purpose:
//   ALU reservation station bank for a Tomasulo-style LC-3b datapath. It holds
//   dispatched ALU operations until both source operands are available. It
//   snoops the common data bus (CDB) for pending operands. It issues the
//   lowest-index ready entry to a single-cycle 16-bit ALU. The result sits in a
//   CDB-formatted output register until the downstream CDB arbiter grants the
//   bus, which it signals with 'flush'.
//
// CDB bus format (packed, MSB first): { valid, tag[TAG_W-1:0], data[15:0] }
//
// Ports:
//   clk             in   clock; all state updates on the rising edge
//   reset           in   asynchronous, active-high; clears all state
//   dispatch_valid  in   dispatch request this cycle
//   dispatch_op     in   ALU op (000 ADD, 001 AND, 010 NOT, 011 PASS, 100 LSHF,
//                        101 RSHFL, 110 RSHFA, 111 PASS)
//   dispatch_vj/vk  in   operand values, used when the matching ready bit is 1
//   dispatch_qj/qk  in   producer ROB tags, used when the matching ready bit is 0
//   dispatch_rj/rk  in   operand-ready flags
//   dispatch_dest   in   destination ROB tag
//   full            out  all DEPTH entries busy (combinational from busy bits)
//   cdb_in          in   CDB broadcast from the arbiter output
//   flush           in   arbiter grant; the result register has been consumed
//   cdb_out         out  registered result toward the arbiter
// -----------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dispatch_valid,
    input  logic [2:0]         dispatch_op,
    input  logic [15:0]        dispatch_vj,
    input  logic [15:0]        dispatch_vk,
    input  logic [TAG_W-1:0]   dispatch_qj,
    input  logic [TAG_W-1:0]   dispatch_qk,
    input  logic               dispatch_rj,
    input  logic               dispatch_rk,
    input  logic [TAG_W-1:0]   dispatch_dest,
    output logic               full,
    input  logic [TAG_W+16:0]  cdb_in,
    input  logic               flush,
    output logic [TAG_W+16:0]  cdb_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ALU opcode encodings
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_PASS  = 3'b011;
    localparam logic [2:0] OP_LSHF  = 3'b100;
    localparam logic [2:0] OP_RSHFL = 3'b101;
    localparam logic [2:0] OP_RSHFA = 3'b110;

    // Single-cycle 16-bit ALU; arithmetic wraps, shift amount is Vk[3:0].
    // Op 111 is unused by the decoder and behaves as PASS.
    function automatic logic [15:0] alu_calc(
        input logic [2:0]  op,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [3:0]  sh;
        logic [15:0] res;
        sh = b[3:0];
        case (op)
            OP_ADD:   res = a + b;
            OP_AND:   res = a & b;
            OP_NOT:   res = ~a;
            OP_PASS:  res = b;
            OP_LSHF:  res = a << sh;
            OP_RSHFL: res = a >> sh;
            OP_RSHFA: res = $unsigned($signed(a) >>> sh);
            default:  res = b;
        endcase
        return res;
    endfunction

    // ---------------------------------------------------------------------
    // Station entry state
    // ---------------------------------------------------------------------
    logic             r_busy [DEPTH];
    logic [2:0]       r_op   [DEPTH];
    logic [15:0]      r_vj   [DEPTH];
    logic [15:0]      r_vk   [DEPTH];
    logic [TAG_W-1:0] r_qj   [DEPTH];
    logic [TAG_W-1:0] r_qk   [DEPTH];
    logic             r_rj   [DEPTH];
    logic             r_rk   [DEPTH];
    logic [TAG_W-1:0] r_dest [DEPTH];

    // Result register (CDB formatted)
    logic             r_res_valid;
    logic [TAG_W-1:0] r_res_tag;
    logic [15:0]      r_res_data;

    // ---------------------------------------------------------------------
    // Combinational decode
    // ---------------------------------------------------------------------
    logic             w_cdb_valid;
    logic [TAG_W-1:0] w_cdb_tag;
    logic [15:0]      w_cdb_data;

    assign w_cdb_valid = cdb_in[TAG_W+16];
    assign w_cdb_tag   = cdb_in[TAG_W+15:16];
    assign w_cdb_data  = cdb_in[15:0];

    logic             w_full;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_ready_any;
    logic [IDX_W-1:0] w_issue_idx;
    logic             w_dispatch;
    logic             w_issue;
    logic [15:0]      w_alu_result;
    logic             w_byp_j;
    logic             w_byp_k;

    // Full flag and lowest-index free entry; a downward scan leaves the lowest hit
    always_comb begin
        w_full       = 1'b1;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_full       = 1'b0;
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end else begin
                w_full = w_full;
            end
        end
    end

    // Lowest-index ready entry; readiness reflects only state at cycle start,
    // so operands snooped this cycle do not make an entry ready until the next
    always_comb begin
        w_ready_any = 1'b0;
        w_issue_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_busy[i] && r_rj[i] && r_rk[i]) begin
                w_ready_any = 1'b1;
                w_issue_idx = IDX_W'(i);
            end else begin
                w_ready_any = w_ready_any;
            end
        end
    end

    assign full = w_full;

    // Dispatch only looks at full at cycle start: an entry freed by an issue
    // in the same cycle is not reused until the following cycle.
    assign w_dispatch = dispatch_valid && !w_full && w_free_found;

    // Issue needs an empty result register, or one being drained this cycle
    assign w_issue = w_ready_any && (!r_res_valid || flush);

    assign w_alu_result = alu_calc(r_op[w_issue_idx], r_vj[w_issue_idx], r_vk[w_issue_idx]);

    // Dispatch-cycle bypass: an operand whose producer broadcasts right now
    // is captured directly instead of waiting for a snoop that would miss it
    assign w_byp_j = !dispatch_rj && w_cdb_valid && (dispatch_qj == w_cdb_tag);
    assign w_byp_k = !dispatch_rk && w_cdb_valid && (dispatch_qk == w_cdb_tag);

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------

    // Entry table: snoop capture, issue release and dispatch allocation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
                r_op[i]   <= 3'b000;
                r_vj[i]   <= 16'h0000;
                r_vk[i]   <= 16'h0000;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_rj[i]   <= 1'b0;
                r_rk[i]   <= 1'b0;
                r_dest[i] <= '0;
            end
        end else begin
            // One broadcast can satisfy both operands of many entries
            for (int i = 0; i < DEPTH; i++) begin
                if (r_busy[i] && w_cdb_valid) begin
                    if (!r_rj[i] && (r_qj[i] == w_cdb_tag)) begin
                        r_vj[i] <= w_cdb_data;
                        r_rj[i] <= 1'b1;
                    end
                    if (!r_rk[i] && (r_qk[i] == w_cdb_tag)) begin
                        r_vk[i] <= w_cdb_data;
                        r_rk[i] <= 1'b1;
                    end
                end
            end

            if (w_issue) begin
                r_busy[w_issue_idx] <= 1'b0;
            end

            // The allocated entry is free at cycle start, so it never
            // collides with the issuing entry or with a snoop update
            if (w_dispatch) begin
                r_busy[w_free_idx] <= 1'b1;
                r_op[w_free_idx]   <= dispatch_op;
                r_qj[w_free_idx]   <= dispatch_qj;
                r_qk[w_free_idx]   <= dispatch_qk;
                r_dest[w_free_idx] <= dispatch_dest;
                r_rj[w_free_idx]   <= dispatch_rj | w_byp_j;
                r_rk[w_free_idx]   <= dispatch_rk | w_byp_k;
                r_vj[w_free_idx]   <= w_byp_j ? w_cdb_data : dispatch_vj;
                r_vk[w_free_idx]   <= w_byp_k ? w_cdb_data : dispatch_vk;
            end
        end
    end

    // Result register: a new issue wins over flush, flush alone empties it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= 16'h0000;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_tag   <= r_dest[w_issue_idx];
            r_res_data  <= w_alu_result;
        end else if (flush) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= 16'h0000;
        end else begin
            r_res_valid <= r_res_valid;
            r_res_tag   <= r_res_tag;
            r_res_data  <= r_res_data;
        end
    end

    assign cdb_out = {r_res_valid, r_res_tag, r_res_data};

endmodule

// File: tb/tb_alu_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_alu_reservation_station
//
// Directed testbench for alu_reservation_station. Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point, well away
// from the next active edge.
// -----------------------------------------------------------------------------
module tb_alu_reservation_station;

    localparam int DEPTH = 3;
    localparam int TAG_W = 3;

    logic               clk;
    logic               reset;
    logic               dispatch_valid;
    logic [2:0]         dispatch_op;
    logic [15:0]        dispatch_vj;
    logic [15:0]        dispatch_vk;
    logic [TAG_W-1:0]   dispatch_qj;
    logic [TAG_W-1:0]   dispatch_qk;
    logic               dispatch_rj;
    logic               dispatch_rk;
    logic [TAG_W-1:0]   dispatch_dest;
    logic               full;
    logic [TAG_W+16:0]  cdb_in;
    logic               flush;
    logic [TAG_W+16:0]  cdb_out;

    int n_checks;
    int n_pass;

    alu_reservation_station #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_op    (dispatch_op),
        .dispatch_vj    (dispatch_vj),
        .dispatch_vk    (dispatch_vk),
        .dispatch_qj    (dispatch_qj),
        .dispatch_qk    (dispatch_qk),
        .dispatch_rj    (dispatch_rj),
        .dispatch_rk    (dispatch_rk),
        .dispatch_dest  (dispatch_dest),
        .full           (full),
        .cdb_in         (cdb_in),
        .flush          (flush),
        .cdb_out        (cdb_out)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_W+16:0] cdb(input logic v, input logic [TAG_W-1:0] t, input logic [15:0] d);
        return {v, t, d};
    endfunction

    task automatic disp(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                        input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                        input logic rj, input logic rk, input logic [TAG_W-1:0] dest);
        dispatch_valid = 1'b1;
        dispatch_op    = op;
        dispatch_vj    = vj;
        dispatch_vk    = vk;
        dispatch_qj    = qj;
        dispatch_qk    = qk;
        dispatch_rj    = rj;
        dispatch_rk    = rk;
        dispatch_dest  = dest;
    endtask

    // ALU vectors: op, vj, vk, dest, expected data
    logic [2:0]  v_op   [7];
    logic [15:0] v_vj   [7];
    logic [15:0] v_vk   [7];
    logic [2:0]  v_dest [7];
    logic [15:0] v_exp  [7];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        dispatch_valid = 1'b0;
        dispatch_op = 3'd0; dispatch_vj = 16'h0; dispatch_vk = 16'h0;
        dispatch_qj = 3'd0; dispatch_qk = 3'd0; dispatch_rj = 1'b0; dispatch_rk = 1'b0;
        dispatch_dest = 3'd0;
        cdb_in = '0;
        flush  = 1'b0;

        v_op[0] = 3'b000; v_vj[0] = 16'hFFFF; v_vk[0] = 16'h0002; v_dest[0] = 3'd1; v_exp[0] = 16'h0001;
        v_op[1] = 3'b001; v_vj[1] = 16'hF0F0; v_vk[1] = 16'h3C3C; v_dest[1] = 3'd2; v_exp[1] = 16'h3030;
        v_op[2] = 3'b010; v_vj[2] = 16'h00F0; v_vk[2] = 16'h1234; v_dest[2] = 3'd3; v_exp[2] = 16'hFF0F;
        v_op[3] = 3'b100; v_vj[3] = 16'h0001; v_vk[3] = 16'h0013; v_dest[3] = 3'd4; v_exp[3] = 16'h0008;
        v_op[4] = 3'b101; v_vj[4] = 16'h8000; v_vk[4] = 16'h0004; v_dest[4] = 3'd5; v_exp[4] = 16'h0800;
        v_op[5] = 3'b110; v_vj[5] = 16'h7000; v_vk[5] = 16'h0004; v_dest[5] = 3'd6; v_exp[5] = 16'h0700;
        v_op[6] = 3'b111; v_vj[6] = 16'h1111; v_vk[6] = 16'hBEEF; v_dest[6] = 3'd7; v_exp[6] = 16'hBEEF;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check_eq("reset_cdb_out", 32'(cdb_out), 32'h0);
        check_eq("reset_full", 32'(full), 32'h0);
        reset = 1'b0;

        // ---------------- ADD, both ready: 2-cycle latency, hold, flush ----------------
        disp(3'b000, 16'h0005, 16'h0003, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
        tick();
        dispatch_valid = 1'b0;
        check_eq("add_n1_empty", 32'(cdb_out), 32'h0);
        tick();
        check_eq("add_result", 32'(cdb_out), 32'(cdb(1'b1, 3'd2, 16'h0008)));
        tick();
        check_eq("add_hold", 32'(cdb_out), 32'(cdb(1'b1, 3'd2, 16'h0008)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("add_flushed", 32'(cdb_out), 32'h0);

        // ---------------- AND waiting on tag 4 via snoop ----------------
        disp(3'b001, 16'h0000, 16'h00FF, 3'd4, 3'd0, 1'b0, 1'b1, 3'd1);
        tick();
        dispatch_valid = 1'b0;
        tick();
        check_eq("and_waiting", 32'(cdb_out), 32'h0);
        cdb_in = cdb(1'b1, 3'd4, 16'h1234);
        tick();
        cdb_in = '0;
        check_eq("and_snoop_n1", 32'(cdb_out), 32'h0);
        tick();
        check_eq("and_result", 32'(cdb_out), 32'(cdb(1'b1, 3'd1, 16'h0034)));
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // ---------------- Fill, full, ignored dispatch, reuse of entry 0 ----------------
        disp(3'b000, 16'h0000, 16'h0001, 3'd6, 3'd0, 1'b0, 1'b1, 3'd3);
        tick();
        disp(3'b000, 16'h0000, 16'h0002, 3'd7, 3'd0, 1'b0, 1'b1, 3'd4);
        tick();
        disp(3'b000, 16'h0000, 16'h0003, 3'd7, 3'd0, 1'b0, 1'b1, 3'd5);
        tick();
        check_eq("full_after_3", 32'(full), 32'h1);
        disp(3'b000, 16'h0001, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1, 3'd6);
        tick();
        dispatch_valid = 1'b0;
        check_eq("full_after_4th", 32'(full), 32'h1);
        cdb_in = cdb(1'b1, 3'd6, 16'h0010);
        tick();
        cdb_in = '0;
        // Entry 0 issues this cycle; a dispatch now must still be refused
        disp(3'b000, 16'h0005, 16'h0005, 3'd0, 3'd0, 1'b1, 1'b1, 3'd6);
        tick();
        dispatch_valid = 1'b0;
        check_eq("full_freed", 32'(full), 32'h0);
        check_eq("e0_result", 32'(cdb_out), 32'(cdb(1'b1, 3'd3, 16'h0011)));
        disp(3'b011, 16'h0000, 16'h00AA, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2);
        tick();
        dispatch_valid = 1'b0;
        check_eq("full_refilled", 32'(full), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("pass_after_flush", 32'(cdb_out), 32'(cdb(1'b1, 3'd2, 16'h00AA)));

        // ---------------- Two ready entries behind an occupied result ----------------
        cdb_in = cdb(1'b1, 3'd7, 16'h0020);
        tick();
        cdb_in = '0;
        check_eq("occupied_hold1", 32'(cdb_out), 32'(cdb(1'b1, 3'd2, 16'h00AA)));
        tick();
        check_eq("occupied_hold2", 32'(cdb_out), 32'(cdb(1'b1, 3'd2, 16'h00AA)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("e1_no_bubble", 32'(cdb_out), 32'(cdb(1'b1, 3'd4, 16'h0022)));
        tick();
        check_eq("e1_hold", 32'(cdb_out), 32'(cdb(1'b1, 3'd4, 16'h0022)));
        check_eq("not_full_one_left", 32'(full), 32'h0);
        flush = 1'b1;
        tick();
        check_eq("e2_result", 32'(cdb_out), 32'(cdb(1'b1, 3'd5, 16'h0023)));
        tick();
        check_eq("drained", 32'(cdb_out), 32'h0);
        tick();
        flush = 1'b0;
        check_eq("no_stray_dest6", 32'(cdb_out), 32'h0);

        // ---------------- Dispatch-cycle bypass, RSHFA ----------------
        disp(3'b110, 16'h0000, 16'h0004, 3'd5, 3'd0, 1'b0, 1'b1, 3'd0);
        cdb_in = cdb(1'b1, 3'd5, 16'h8000);
        tick();
        dispatch_valid = 1'b0;
        cdb_in = '0;
        tick();
        check_eq("bypass_rshfa", 32'(cdb_out), 32'(cdb(1'b1, 3'd0, 16'hF800)));
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // ---------------- ALU operation table ----------------
        for (int k = 0; k < 7; k++) begin
            disp(v_op[k], v_vj[k], v_vk[k], 3'd0, 3'd0, 1'b1, 1'b1, v_dest[k]);
            tick();
            dispatch_valid = 1'b0;
            tick();
            check_eq($sformatf("alu_op%0d", v_op[k]), 32'(cdb_out), 32'(cdb(1'b1, v_dest[k], v_exp[k])));
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end

        // ---------------- Reset mid-operation ----------------
        disp(3'b000, 16'h0003, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1, 3'd1);
        tick();
        disp(3'b000, 16'h0000, 16'h0001, 3'd3, 3'd0, 1'b0, 1'b1, 3'd2);
        tick();
        disp(3'b000, 16'h0000, 16'h0002, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3);
        tick();
        dispatch_valid = 1'b0;
        check_eq("pre_reset_result", 32'(cdb_out), 32'(cdb(1'b1, 3'd1, 16'h0007)));
        #2;
        reset = 1'b1;
        #1;
        check_eq("midreset_cdb_out", 32'(cdb_out), 32'h0);
        check_eq("midreset_full", 32'(full), 32'h0);
        tick();
        reset = 1'b0;
        cdb_in = cdb(1'b1, 3'd3, 16'h0100);
        tick();
        cdb_in = '0;
        tick();
        tick();
        check_eq("post_reset_no_stale", 32'(cdb_out), 32'h0);
        check_eq("post_reset_full", 32'(full), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- ALU reservation station bank for the Tomasulo LC-3b datapath, directly upstream of the CDB arbiter.
- Accepts dispatched ALU ops, snoops the CDB for pending operands, and issues the lowest-index ready entry to an internal single-cycle ALU.
- Holds the result in a CDB-formatted output register until the arbiter grants the bus, signalled by the flush input.

Parameters:
- DEPTH, 3, number of station entries (1..8).
- TAG_W, 3, ROB tag width carried on CDB and operand tags.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dispatch_valid  in  1  dispatch request this cycle.
- dispatch_op  in  3  ALU op: 000 ADD, 001 AND, 010 NOT(Vj), 011 PASS(Vk), 100 LSHF, 101 RSHFL, 110 RSHFA; 111 is treated as PASS.
- dispatch_vj / dispatch_vk  in  16  operand values, meaningful when the matching ready bit is 1.
- dispatch_qj / dispatch_qk  in  TAG_W  producer ROB tags, meaningful when the matching ready bit is 0.
- dispatch_rj / dispatch_rk  in  1  operand-ready flags.
- dispatch_dest  in  TAG_W  destination ROB tag.
- full  out  1  all DEPTH entries busy.
- cdb_in  in  CDB  broadcast bus (valid, tag[TAG_W], data[16]) from the arbiter output.
- flush  in  1  arbiter grant; result register consumed.
- cdb_out  out  CDB  result to the arbiter (valid, tag = dest, data).

Behaviour:
- Reset, async: all entries busy=0, result register cleared, cdb_out = 0 (valid 0), full = 0.
- full is combinational from the current busy bits.

Dispatch:
- Accepted when dispatch_valid=1 and full=0, written at the clock edge into the lowest-index free entry.
- Ignored when full=1, even if an issue frees an entry in the same cycle.

Dispatch bypass:
- If an operand is not ready, cdb_in.valid=1 and cdb_in.tag equals its q tag in the dispatch cycle, the entry stores cdb_in.data as that operand, marked ready.

Snoop:
- Each cycle with cdb_in.valid=1, every busy entry whose non-ready operand tag matches cdb_in.tag captures the data and sets the operand ready.
- One broadcast may satisfy both operands and multiple entries.

Ready and issue:
- An entry is ready when busy and both operands are ready at the start of the cycle. Operands captured by snoop this cycle count from the next cycle.
- Issue is allowed when the result register is empty, or when flush=1 this cycle.
- The lowest-index ready entry issues. At the edge its busy bit clears and the result register loads {valid=1, tag=dest, data=ALU(op,Vj,Vk)}.
- At most one issue per cycle.

ALU rules (16-bit, wrap on overflow):
- ADD and AND: Vj op Vk.
- NOT: ~Vj.
- PASS: Vk.
- Shifts: Vj shifted by Vk[3:0]; RSHFA is sign-extending.

Result register:
- Holds its value while flush=0.
- flush=1 with no issue: cleared to 0.
- flush=1 with an issue in the same cycle: the new result loads (load wins).
- flush=1 while the register is empty: no effect.

Latency:
- Dispatch with both operands ready in cycle N: issue in N+1, cdb_out.valid=1 in N+2.
- Snoop capture in cycle N: issue no earlier than N+1.

Simultaneous dispatch, snoop and issue in one cycle are all performed; the issuing entry and the newly allocated entry are always distinct.

Reset mid-operation discards all entries and any pending result with no partial broadcast.

Test Plan:
- Reset, then dispatch ADD vj=0x0005 vk=0x0003 dest=2, both ready -> cdb_out={1,2,0x0008} two cycles later; held until flush=1, cleared the cycle after.
- Dispatch AND rj=0 qj=4, vk=0x00FF ready, dest=1; later cdb_in={1,4,0x1234} -> cdb_out={1,1,0x0034} two cycles after the broadcast.
- Dispatch 3 ops with unready operands -> full=1; a 4th dispatch is ignored. A matching broadcast issues entry 0; the next dispatch lands in entry 0.
- Dispatch with qj=5 while cdb_in={1,5,0x8000} in the same cycle, op RSHFA vk=0x0004 -> result 0xF800.
- Two entries ready, result register occupied: flush=1 -> entry 0 result loads in the same edge with no empty bubble; entry 1 issues after the next flush.
- Assert reset while cdb_out.valid=1 and 2 entries are busy -> cdb_out=0 and full=0 immediately; no stale result appears afterwards.
